// File: rtl/pipearch_writepack.sv
// ---------------------------------------------------------------------------
// pipearch_writepack
//
// Upstream producer for the write-forward stage. Narrow words arrive on a
// valid/ready handshake and are packed WORDS_PER_LINE at a time into one line.
// Each completed line is issued as a single-cycle write (wf_we) to the
// write-forward port. An operation is started by op_start and completes with
// a one-cycle op_done pulse.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   op_start      start pulse, only honoured while idle
//   op_done       one-cycle completion pulse
//   regs[0]       [15:0] lines per iteration, [31:16] iteration count
//   regs[1]       [ADDR_WIDTH-1:0] base address, [31] fifobram select
//   in_valid      input word valid
//   in_data       input word
//   in_ready      block accepts a word this cycle
//   wf_we         line write strobe, one cycle per line
//   wf_waddr      line address (base + line index, wraps)
//   wf_wdata      packed line, word 0 in the LSBs
//   wf_wfifobram  fifobram select latched at op_start
// ---------------------------------------------------------------------------
module pipearch_writepack #(
  parameter  int WORD_WIDTH     = 32,
  parameter  int WORDS_PER_LINE = 16,
  parameter  int ADDR_WIDTH     = 16,
  localparam int LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  output logic                  op_done,
  input  logic [31:0]           regs [2],
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wf_we,
  output logic [ADDR_WIDTH-1:0] wf_waddr,
  output logic [LINE_WIDTH-1:0] wf_wdata,
  output logic                  wf_wfifobram
);

  localparam int WCW = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PACK   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [15:0]           num_lines;
  logic [15:0]           num_iters;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  fifobram_sel;
  logic [WCW-1:0]        word_cnt;
  logic [15:0]           line_cnt;
  logic [15:0]           iter_cnt;
  logic [LINE_WIDTH-1:0] line_buf;
  logic [LINE_WIDTH-1:0] line_nxt;
  logic [ADDR_WIDTH-1:0] waddr_nxt;

  logic start_op;
  logic accept;
  logic word_last;
  logic line_last;
  logic iter_last;

  // Only the address bits and the select bit of regs[1] are meaningful.
  logic unused_regs;
  assign unused_regs = ^regs[1][30:ADDR_WIDTH];

  assign word_last = (word_cnt == WCW'(WORDS_PER_LINE - 1));
  assign line_last = (line_cnt == num_lines - 16'd1);
  assign iter_last = (iter_cnt == num_iters - 16'd1);
  assign waddr_nxt = base_addr + ADDR_WIDTH'(line_cnt);

  // Line under construction with the current input word merged in; this is
  // what gets written out when the last word of a line is accepted.
  always_comb begin
    line_nxt = line_buf;
    line_nxt[word_cnt*WORD_WIDTH +: WORD_WIDTH] = in_data;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/control outputs. A zero line or iteration count
  // skips packing and goes straight to FINISH so op_done still pulses.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    op_done   = 1'b0;
    start_op  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (op_start) begin
          start_op = 1'b1;
          if (regs[0][15:0] == 16'd0 || regs[0][31:16] == 16'd0) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = PACK;
          end
        end
      end
      PACK: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && word_last && line_last && iter_last) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        op_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latching, word packing, line/iteration counting and the
  // registered write port. Write outputs only change when a line is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_lines    <= '0;
      num_iters    <= '0;
      base_addr    <= '0;
      fifobram_sel <= 1'b0;
      word_cnt     <= '0;
      line_cnt     <= '0;
      iter_cnt     <= '0;
      line_buf     <= '0;
      wf_we        <= 1'b0;
      wf_waddr     <= '0;
      wf_wdata     <= '0;
      wf_wfifobram <= 1'b0;
    end else begin
      wf_we <= 1'b0;
      if (start_op) begin
        num_lines    <= regs[0][15:0];
        num_iters    <= regs[0][31:16];
        base_addr    <= regs[1][ADDR_WIDTH-1:0];
        fifobram_sel <= regs[1][31];
        word_cnt     <= '0;
        line_cnt     <= '0;
        iter_cnt     <= '0;
        line_buf     <= '0;
      end
      if (accept) begin
        line_buf <= line_nxt;
        word_cnt <= word_cnt + WCW'(1);
        if (word_last) begin
          wf_we        <= 1'b1;
          wf_wdata     <= line_nxt;
          wf_waddr     <= waddr_nxt;
          wf_wfifobram <= fifobram_sel;
          if (line_last) begin
            line_cnt <= '0;
            iter_cnt <= iter_cnt + 16'd1;
          end else begin
            line_cnt <= line_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipearch_writepack.sv
// ---------------------------------------------------------------------------
// tb_pipearch_writepack
//
// Self-checking bench for pipearch_writepack with default parameters
// (32-bit words, 16 words per line, 16-bit addresses). Expected writes are
// derived from the word stream: write j carries words 16j..16j+15 and goes to
// base + (j mod num_lines).
// ---------------------------------------------------------------------------
module tb_pipearch_writepack;

  localparam int WW = 32;
  localparam int WPL = 16;
  localparam int AW = 16;
  localparam int LW = WW * WPL;

  logic          clk;
  logic          reset;
  logic          op_start;
  logic          op_done;
  logic [31:0]   regs [2];
  logic          in_valid;
  logic [WW-1:0] in_data;
  logic          in_ready;
  logic          wf_we;
  logic [AW-1:0] wf_waddr;
  logic [LW-1:0] wf_wdata;
  logic          wf_wfifobram;

  int checks = 0;
  int errors = 0;

  // Model of the held write-port outputs.
  logic [AW-1:0] hold_addr = '0;
  logic [LW-1:0] hold_data = '0;
  logic          hold_sel  = 1'b0;

  typedef struct {
    logic [15:0] nl;
    logic [15:0] ni;
    logic [15:0] base;
    bit          sel;
    int          bubble;   // 0 back-to-back, 1 toggle, 2 random
    bit          ramp;     // words are 0,1,2,...
    int          exp_writes;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  pipearch_writepack dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_done      (op_done),
    .regs         (regs),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wf_we        (wf_we),
    .wf_waddr     (wf_waddr),
    .wf_wdata     (wf_wdata),
    .wf_wfifobram (wf_wfifobram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [LW-1:0] act,
                              input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one complete operation and checks every cycle against the model.
  task automatic apply_stimulus(input logic [15:0] nl, input logic [15:0] ni,
                                input logic [15:0] base, input bit sel,
                                input int bubble, input bit ramp,
                                output int nwrites, output logic [15:0] first_addr,
                                output logic [15:0] last_addr);
    logic [WW-1:0] words[$];
    logic [AW-1:0] exp_addr[$];
    logic [LW-1:0] exp_data[$];
    logic [LW-1:0] d;
    int total, nlines, idx, wcnt, line_acc_cyc, done_cyc, budget;
    bit zero, exp_we, exp_done, exp_ready, valid, finished;

    total  = int'(nl) * int'(ni) * WPL;
    nlines = int'(nl) * int'(ni);
    zero   = (total == 0);
    for (int i = 0; i < total; i++) words.push_back(ramp ? WW'(i) : WW'($urandom));
    for (int j = 0; j < nlines; j++) begin
      for (int k = 0; k < WPL; k++) d[k*WW +: WW] = words[j*WPL + k];
      exp_addr.push_back(AW'(int'(base) + (j % int'(nl))));
      exp_data.push_back(d);
    end

    nwrites = 0;
    first_addr = '0;
    last_addr = '0;
    @(negedge clk);
    regs[0] = {ni, nl};
    regs[1] = {sel, 15'h0, base};
    op_start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    op_start = 1'b0;
    regs[0] = $urandom;
    regs[1] = $urandom;

    idx = 0;
    wcnt = 0;
    line_acc_cyc = -10;
    done_cyc = -10;
    finished = 1'b0;
    budget = total * 4 + 40;
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      exp_we    = !zero && (cyc == line_acc_cyc + 1);
      exp_done  = zero ? (cyc == 0) : (exp_we && idx == total);
      exp_ready = !zero && (idx < total);

      if (wf_we === 1'b1) nwrites++;
      check_output("we", LW'(wf_we), LW'(exp_we));
      check_output("op_done", LW'(op_done), LW'(exp_done));
      check_output("in_ready", LW'(in_ready), LW'(exp_ready));
      if (exp_we) begin
        check_output("waddr", LW'(wf_waddr), LW'(exp_addr[wcnt]));
        check_output("wdata", wf_wdata, exp_data[wcnt]);
        check_output("wfifobram", LW'(wf_wfifobram), LW'(sel));
        if (wcnt == 0) first_addr = wf_waddr;
        last_addr = wf_waddr;
        hold_addr = exp_addr[wcnt];
        hold_data = exp_data[wcnt];
        hold_sel  = sel;
        wcnt++;
      end else begin
        check_output("hold waddr", LW'(wf_waddr), LW'(hold_addr));
        check_output("hold wdata", wf_wdata, hold_data);
        check_output("hold wfifobram", LW'(wf_wfifobram), LW'(hold_sel));
      end
      if (exp_done) done_cyc = cyc;
      if (cyc == done_cyc + 1) finished = 1'b1;

      // A stray start mid-operation must be ignored.
      op_start = (cyc == 5);
      if (cyc == 5) begin
        regs[0] = 32'h0001_0001;
        regs[1] = 32'h8000_1234;
      end
      case (bubble)
        0:       valid = (idx < total);
        1:       valid = (idx < total) && (cyc % 2 == 0);
        default: valid = (idx < total) && ($urandom_range(0, 3) != 0);
      endcase
      in_valid = valid;
      in_data  = valid ? words[idx] : WW'($urandom);
      if (valid && exp_ready) begin
        idx++;
        if (idx % WPL == 0) line_acc_cyc = cyc;
      end
    end
    op_start = 1'b0;
    in_valid = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: op did not complete, writes seen %0d of %0d", wcnt, nlines);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int nw;
    logic [15:0] fa, la;

    reset = 1'b0;
    op_start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    regs[0] = '0;
    regs[1] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_output("reset we", LW'(wf_we), '0);
    check_output("reset op_done", LW'(op_done), '0);
    check_output("reset in_ready", LW'(in_ready), '0);
    check_output("reset waddr", LW'(wf_waddr), '0);
    check_output("reset wdata", wf_wdata, '0);
    check_output("reset wfifobram", LW'(wf_wfifobram), '0);
    reset = 1'b1;

    // Directed table: {lines, iters, base, sel, bubble, ramp, writes, first, last}.
    vecs.push_back('{16'd1, 16'd1, 16'h0010, 1'b0, 0, 1'b1, 1, 16'h0010, 16'h0010});
    vecs.push_back('{16'd4, 16'd2, 16'h0000, 1'b1, 0, 1'b0, 8, 16'h0000, 16'h0003});
    vecs.push_back('{16'd1, 16'd1, 16'h0020, 1'b0, 1, 1'b0, 1, 16'h0020, 16'h0020});
    vecs.push_back('{16'd0, 16'd1, 16'h0030, 1'b1, 0, 1'b0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{16'd4, 16'd1, 16'hFFFE, 1'b1, 0, 1'b0, 4, 16'hFFFE, 16'h0001});
    vecs.push_back('{16'd3, 16'd0, 16'h0040, 1'b0, 0, 1'b0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{16'd2, 16'd3, 16'h0100, 1'b0, 2, 1'b0, 6, 16'h0100, 16'h0101});
    foreach (vecs[v]) begin
      apply_stimulus(vecs[v].nl, vecs[v].ni, vecs[v].base, vecs[v].sel,
                     vecs[v].bubble, vecs[v].ramp, nw, fa, la);
      check_output($sformatf("vec%0d writes", v), LW'(nw), LW'(vecs[v].exp_writes));
      if (vecs[v].exp_writes > 0) begin
        check_output($sformatf("vec%0d first addr", v), LW'(fa), LW'(vecs[v].exp_first));
        check_output($sformatf("vec%0d last addr", v), LW'(la), LW'(vecs[v].exp_last));
      end
    end

    // Reset in the middle of a line: 7 words in, then reset.
    @(negedge clk);
    regs[0] = 32'h0001_0001;
    regs[1] = 32'h0000_0050;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_output("midreset we", LW'(wf_we), '0);
    check_output("midreset in_ready", LW'(in_ready), '0);
    check_output("midreset op_done", LW'(op_done), '0);
    check_output("midreset waddr", LW'(wf_waddr), '0);
    check_output("midreset wdata", wf_wdata, '0);
    hold_addr = '0;
    hold_data = '0;
    hold_sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(16'd1, 16'd1, 16'h0050, 1'b1, 0, 1'b0, nw, fa, la);
    check_output("post-reset writes", LW'(nw), LW'(1));

    // Randomized operations.
    for (int r = 0; r < 6; r++) begin
      logic [15:0] rnl, rni;
      rnl = 16'($urandom_range(1, 3));
      rni = 16'($urandom_range(1, 2));
      apply_stimulus(rnl, rni, 16'($urandom), 1'($urandom), 2, 1'b0, nw, fa, la);
      check_output($sformatf("rand%0d writes", r), LW'(nw), LW'(int'(rnl) * int'(rni)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
